// File: rtl/t_flipflop_counter.sv
// Bank of WIDTH T flip-flops. Each bit toggles from an external mask or an
// internal carry/borrow chain, with synchronous load, wrap/saturate limits and a registered terminal-count pulse.
module t_flipflop_counter #(
  parameter int          WIDTH       = 8,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] q_p0;
  logic             tc_p0;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             lim;

  // True when the current count sits at the limit of the selected direction.
  function automatic logic at_limit(input logic [1:0] m, input logic [WIDTH-1:0] v);
    logic r;
    r = 1'b0;
    case (mode_e'(m))
      MODE_UP:   r = &v;
      MODE_DOWN: r = ~|v;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Saturation suppresses every toggle term once the limit is reached.
  function automatic logic [WIDTH-1:0] sat_toggle(input logic [WIDTH-1:0] tv, input logic at_lim);
    return (SATURATE && at_lim) ? '0 : tv;
  endfunction

  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_p0[i-1];
      dn_t[i] = dn_t[i-1] & ~q_p0[i-1];
    end
  end

  always_comb begin
    tog    = '0;
    q_nxt  = q_p0;
    tc_nxt = 1'b0;
    lim    = at_limit(mode, q_p0);
    if (load) begin
      q_nxt = d;
    end else if (en) begin
      tc_nxt = lim;
      case (mode_e'(mode))
        MODE_TOGGLE: tog = t;
        MODE_UP:     tog = sat_toggle(up_t, lim);
        MODE_DOWN:   tog = sat_toggle(dn_t, lim);
        default:     tog = '0;
      endcase
      q_nxt = q_p0 ^ tog;
    end
  end

  // Stage p0: flip-flop state and terminal-count pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0  <= RST_Q;
      tc_p0 <= 1'b0;
    end else begin
      q_p0  <= q_nxt;
      tc_p0 <= tc_nxt;
    end
  end

  assign q    = q_p0;
  assign qbar = ~q_p0;
  assign tc   = tc_p0;

endmodule

// File: tb/tb_t_flipflop_counter.sv
// Directed bench: a wrapping and a saturating 4-bit counter plus a 1-bit
// instance share one stimulus stream; all expectations are hand-computed.
module tb_t_flipflop_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic       load;
  logic [3:0] d;

  logic [3:0] q_w, qbar_w, q_s, qbar_s;
  logic       tc_w, tc_s;
  logic [0:0] q_1, qbar_1;
  logic       tc_1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  t_flipflop_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VALUE(5)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .q(q_w), .qbar(qbar_w), .tc(tc_w));

  t_flipflop_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VALUE(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .load(load), .d(d),
    .q(q_s), .qbar(qbar_s), .tc(tc_s));

  t_flipflop_counter #(.WIDTH(1), .SATURATE(1'b0), .RESET_VALUE(0)) dut_1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t[0:0]), .load(load), .d(d[0:0]),
    .q(q_1), .qbar(qbar_1), .tc(tc_1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks both 4-bit instances after an edge.
  task automatic chk4(input string tag, input logic [3:0] qw, input logic tw,
                      input logic [3:0] qs, input logic ts);
    check({tag, ".q_w"}, 32'(q_w), 32'(qw));
    check({tag, ".tc_w"}, 32'(tc_w), 32'(tw));
    check({tag, ".q_s"}, 32'(q_s), 32'(qs));
    check({tag, ".tc_s"}, 32'(tc_s), 32'(ts));
  endtask

  task automatic chk1(input string tag, input logic q1, input logic t1);
    check({tag, ".q_1"}, 32'(q_1), 32'(q1));
    check({tag, ".tc_1"}, 32'(tc_1), 32'(t1));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; t = 4'h0; load = 1'b0; d = 4'h0;
    repeat (3) step();
    chk4("rst", 4'h5, 1'b0, 4'h5, 1'b0);
    check("rst.qbar_w", 32'(qbar_w), 32'hA);
    chk1("rst", 1'b0, 1'b0);

    rst_n = 1'b1;
    step();
    chk4("rel", 4'h5, 1'b0, 4'h5, 1'b0);

    // Up-count through the wrap / saturation point
    load = 1'b1; d = 4'hE;
    step();
    chk4("ldE", 4'hE, 1'b0, 4'hE, 1'b0);
    load = 1'b0; en = 1'b1; mode = 2'b01;
    step(); chk4("up1", 4'hF, 1'b0, 4'hF, 1'b0); chk1("up1", 1'b1, 1'b0);
    step(); chk4("up2", 4'h0, 1'b1, 4'hF, 1'b1); chk1("up2", 1'b0, 1'b1);
    check("up2.qbar_w", 32'(qbar_w), 32'hF);
    step(); chk4("up3", 4'h1, 1'b0, 4'hF, 1'b1); chk1("up3", 1'b1, 1'b0);

    // Down-count through zero
    load = 1'b1; d = 4'h1;
    step(); chk4("ld1", 4'h1, 1'b0, 4'h1, 1'b0);
    load = 1'b0; mode = 2'b10;
    step(); chk4("dn1", 4'h0, 1'b0, 4'h0, 1'b0); chk1("dn1", 1'b0, 1'b0);
    step(); chk4("dn2", 4'hF, 1'b1, 4'h0, 1'b1); chk1("dn2", 1'b1, 1'b1);
    step(); chk4("dn3", 4'hE, 1'b0, 4'h0, 1'b1); chk1("dn3", 1'b0, 1'b0);
    check("dn3.qbar_s", 32'(qbar_s), 32'hF);

    // Toggle-by-mask mode
    load = 1'b1; d = 4'h0;
    step();
    load = 1'b0; mode = 2'b00; t = 4'b1010;
    step(); chk4("tg1", 4'hA, 1'b0, 4'hA, 1'b0); chk1("tg1", 1'b0, 1'b0);
    step(); chk4("tg2", 4'h0, 1'b0, 4'h0, 1'b0);
    step(); chk4("tg3", 4'hA, 1'b0, 4'hA, 1'b0);
    t = 4'h0;
    step(); chk4("tg0", 4'hA, 1'b0, 4'hA, 1'b0);
    t = 4'b0001;
    step(); chk1("tg1b", 1'b1, 1'b0);
    check("tg1b.q_w", 32'(q_w), 32'hB);

    // Hold mode at all-ones never counts or flags
    load = 1'b1; d = 4'hF;
    step();
    load = 1'b0; mode = 2'b11;
    step(); chk4("hold", 4'hF, 1'b0, 4'hF, 1'b0);

    // Load beats an enabled count sitting at the limit
    en = 1'b1; mode = 2'b01; load = 1'b1; d = 4'hC;
    step(); chk4("prio", 4'hC, 1'b0, 4'hC, 1'b0);
    load = 1'b0; en = 1'b0;
    step(); chk4("en0", 4'hC, 1'b0, 4'hC, 1'b0);
    load = 1'b1; d = 4'hF;
    step();
    load = 1'b0;
    step(); chk4("en0lim", 4'hF, 1'b0, 4'hF, 1'b0);

    // Asynchronous reset between edges while tc is high
    load = 1'b1; d = 4'hE;
    step();
    load = 1'b0; en = 1'b1; mode = 2'b01;
    step();
    step(); chk4("pre", 4'h0, 1'b1, 4'hF, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk4("arst", 4'h5, 1'b0, 4'h5, 1'b0);
    check("arst.qbar_w", 32'(qbar_w), 32'hA);
    step(); chk4("arst2", 4'h5, 1'b0, 4'h5, 1'b0);
    rst_n = 1'b1;
    step(); chk4("res1", 4'h6, 1'b0, 4'h6, 1'b0);
    step(); chk4("res2", 4'h7, 1'b0, 4'h7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/t_flipflop_counter.md
Name: t_flipflop_counter

Overview:
Parametrised bank of WIDTH T flip-flops sharing one clock. Each bit has a toggle-enable term. That term comes from an external per-bit mask (toggle mode) or from an internal carry/borrow chain (up/down count modes). The block also supports synchronous load, wrap or saturate at the count limits, and a registered terminal-count pulse. It is the generalised successor of the single-bit T flip-flop and is used as a general divider, counter or toggle register.

Parameters:
WIDTH, 8, number of T flip-flops (register width); must be >= 1
SATURATE, 0, 0 = counter wraps at limits; 1 = counter holds at all-ones (up) or zero (down)
RESET_VALUE, 0, value of q on reset; truncated to WIDTH bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable for mode operations (does not gate load)
mode  input  2  00 = toggle by mask, 01 = count up, 10 = count down, 11 = hold
t  input  WIDTH  per-bit toggle mask; used only in mode 00
load  input  1  synchronous load strobe
d  input  WIDTH  load data
q  output  WIDTH  flip-flop state
qbar  output  WIDTH  bitwise complement of q (combinational from q)
tc  output  1  registered terminal-count pulse

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - q = RESET_VALUE[WIDTH-1:0]
  - qbar = ~q
  - tc = 0
  - Held while rst_n is low.
  - First active edge is the first rising clk edge after rst_n deasserts.
- Priority at each rising clk edge: rst_n > load > (en and mode).
- load=1: q <= d, regardless of en and mode. tc <= 0.
- load=0, en=0: q holds. tc <= 0.
- load=0, en=1, state updates by mode:
  - Mode 00: q <= q ^ t. Bits with t[i]=1 toggle; other bits hold.
  - Mode 01: toggle term T[0]=1, T[i] = &q[i-1:0]. Result equals q+1 mod 2^WIDTH.
  - Mode 10: toggle term T[0]=1, T[i] = &~q[i-1:0]. Result equals q-1 mod 2^WIDTH.
  - Mode 11: q holds.
  - Modes 01/10 must be built as toggle-enable logic feeding T-type bit updates (q[i] <= q[i] ^ T[i]), not an adder.
- Limits:
  - Up at all-ones: SATURATE=0 gives q <= 0; SATURATE=1 holds all-ones.
  - Down at zero: SATURATE=0 gives q <= all-ones; SATURATE=1 holds 0.
- tc (registered, 1-cycle latency):
  - Next value is 1 iff load=0, en=1, and either (mode=01 and q=all-ones) or (mode=10 and q=0) before the edge.
  - Otherwise next value is 0.
  - Independent of SATURATE. Under saturation with continued counting into the limit, tc stays high every cycle.
- Mode 00 and mode 11 never assert tc.
- qbar tracks q with zero cycle latency. There is no separate qbar register.
- WIDTH=1: modes 00 (with t=1), 01 and 10 all toggle the single bit, matching a plain T flip-flop.
  - tc in mode 01 fires when q=1; in mode 10 when q=0.
- Mode changes take effect on the edge at which they are sampled. There is no pipeline and no pending state.
- Reset asserted mid-count: q and tc clear immediately. No partial update occurs on the next edge.
- Inputs are synchronous to clk. There are no X-propagation requirements beyond reset.

Test Plan:
- WIDTH=4, RESET_VALUE=4'h5: hold rst_n=0, toggle clk -> q=4'h5, qbar=4'hA, tc=0. Release rst_n -> no change until first enabled edge.
- WIDTH=4, SATURATE=0, en=1, mode=01 from q=4'hE -> successive edges give q=4'hF, then 4'h0, then 4'h1. tc=1 exactly in the cycle after the F->0 edge, else 0.
- WIDTH=4, SATURATE=1, mode=10 from q=4'h1 -> q=0, 0, 0 on three edges. tc=0, 1, 1 (high each cycle after a count attempted at zero).
- WIDTH=4, mode=00, q=4'h0, t=4'b1010 for 3 edges -> q=4'hA, 4'h0, 4'hA. tc stays 0. With t=0 -> q holds.
- Priority: q=4'h3, en=1, mode=01, load=1, d=4'hC -> q=4'hC, tc=0. Then en=0, load=0 -> q holds at 4'hC.
- Async reset mid-operation: counting up, pull rst_n low between edges -> q=RESET_VALUE and tc=0 immediately, without a clock edge. Counting resumes from RESET_VALUE after release.
